// File: rtl/dbus_responder.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | dbus_responder : byte-masked data-bus memory with fixed-latency loads      |
// | Revision 1.0                                                               |
// +---------------------------------------------------------------------------+
module dbus_responder #(
  parameter int DEPTH        = 256,
  parameter int LATENCY      = 2,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic        io_clk,
  input  logic        io_resetn,
  input  logic        io_stall,
  input  logic        io_dBus_cmd_valid,
  output logic        io_dBus_cmd_ready,
  input  logic [63:0] io_dBus_cmd_payload_address,
  input  logic [63:0] io_dBus_cmd_payload_data,
  input  logic [7:0]  io_dBus_cmd_payload_mask,
  input  logic        io_dBus_cmd_payload_write,
  input  logic [15:0] io_dBus_cmd_payload_id,
  output logic        io_dBus_rsp_valid,
  output logic [63:0] io_dBus_rsp_payload_data,
  output logic [15:0] io_dBus_rsp_payload_id
);

  localparam int                 c_IDX_W = $clog2(DEPTH);
  localparam int                 c_CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [c_CNT_W-1:0] c_MAX   = c_CNT_W'(MAX_INFLIGHT);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  logic [63:0]        r_mem [DEPTH];
  logic [LATENCY-1:0] r_vld;
  logic [63:0]        r_data [LATENCY];
  logic [15:0]        r_id [LATENCY];
  logic [c_CNT_W-1:0] r_inflight;

  logic [c_IDX_W-1:0] w_idx;
  logic               w_acc;
  logic               w_load;
  logic               w_store;
  logic               w_unused_addr;

  // Only the word-index bits matter; everything else wraps away.
  assign w_idx         = io_dBus_cmd_payload_address[c_IDX_W+2:3];
  assign w_unused_addr = ^{io_dBus_cmd_payload_address[63:c_IDX_W+3],
                           io_dBus_cmd_payload_address[2:0]};

  assign io_dBus_cmd_ready = io_resetn && !io_stall && (r_inflight < c_MAX);
  assign w_acc             = io_dBus_cmd_valid && io_dBus_cmd_ready;
  assign w_load            = w_acc && !io_dBus_cmd_payload_write;
  assign w_store           = w_acc && io_dBus_cmd_payload_write;

  // Memory contents survive reset.
  always_ff @(posedge io_clk) begin
    if (w_store) begin
      for (int b = 0; b < 8; b++) begin
        if (io_dBus_cmd_payload_mask[b]) begin
          r_mem[w_idx][8*b +: 8] <= io_dBus_cmd_payload_data[8*b +: 8];
        end
      end
    end
  end

  // Stage 0 captures the word at the accept edge; idle stages carry zeros.
  always_ff @(posedge io_clk or negedge io_resetn) begin
    if (!io_resetn) begin
      r_vld[0]  <= 1'b0;
      r_data[0] <= '0;
      r_id[0]   <= '0;
    end else begin
      r_vld[0]  <= w_load;
      r_data[0] <= w_load ? r_mem[w_idx] : '0;
      r_id[0]   <= w_load ? io_dBus_cmd_payload_id : '0;
    end
  end

  for (genvar k = 1; k < LATENCY; k++) begin : g_stage
    always_ff @(posedge io_clk or negedge io_resetn) begin
      if (!io_resetn) begin
        r_vld[k]  <= 1'b0;
        r_data[k] <= '0;
        r_id[k]   <= '0;
      end else begin
        r_vld[k]  <= r_vld[k-1];
        r_data[k] <= r_data[k-1];
        r_id[k]   <= r_id[k-1];
      end
    end
  end

  always_ff @(posedge io_clk or negedge io_resetn) begin
    if (!io_resetn) begin
      r_inflight <= '0;
    end else begin
      case ({w_load, io_dBus_rsp_valid})
        2'b10:   r_inflight <= r_inflight + c_ONE;
        2'b01:   r_inflight <= r_inflight - c_ONE;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign io_dBus_rsp_valid        = r_vld[LATENCY-1];
  assign io_dBus_rsp_payload_data = r_data[LATENCY-1];
  assign io_dBus_rsp_payload_id   = r_id[LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_dbus_responder.sv
`default_nettype none
// Testbench for dbus_responder: directed vectors, corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_dbus_responder;

  localparam int DEPTH        = 256;
  localparam int LATENCY      = 2;
  localparam int MAX_INFLIGHT = 2;

  logic        io_clk = 1'b0;
  logic        io_resetn;
  logic        io_stall;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [63:0] cmd_addr;
  logic [63:0] cmd_data;
  logic [7:0]  cmd_mask;
  logic        cmd_write;
  logic [15:0] cmd_id;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic [15:0] rsp_id;

  dbus_responder #(
    .DEPTH(DEPTH), .LATENCY(LATENCY), .MAX_INFLIGHT(MAX_INFLIGHT)
  ) dut (
    .io_clk                      (io_clk),
    .io_resetn                   (io_resetn),
    .io_stall                    (io_stall),
    .io_dBus_cmd_valid           (cmd_valid),
    .io_dBus_cmd_ready           (cmd_ready),
    .io_dBus_cmd_payload_address (cmd_addr),
    .io_dBus_cmd_payload_data    (cmd_data),
    .io_dBus_cmd_payload_mask    (cmd_mask),
    .io_dBus_cmd_payload_write   (cmd_write),
    .io_dBus_cmd_payload_id      (cmd_id),
    .io_dBus_rsp_valid           (rsp_valid),
    .io_dBus_rsp_payload_data    (rsp_data),
    .io_dBus_rsp_payload_id      (rsp_id)
  );

  always #5 io_clk = ~io_clk;

  // Reference model: byte-level memory with known-byte tracking, and a queue
  // of pending responses tagged with the sample index they are due at.
  typedef struct {
    int          due;
    logic [63:0] d;
    logic [63:0] k;
    logic [15:0] id;
  } pend_t;

  logic [63:0] m_data  [DEPTH];
  logic [63:0] m_known [DEPTH];
  pend_t       q[$];
  int          t = 0;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h (sample %0d)", name, got, exp, t);
    end
  endtask

  // One cycle: drive inputs, compare outputs with the model, advance model.
  task automatic step(input bit v, input bit w, input logic [63:0] a, input logic [63:0] dd,
                      input logic [7:0] m, input logic [15:0] id, input bit st,
                      output bit acc, output bit rv, output logic [63:0] rd, output logic [15:0] rid);
    bit    er;
    int    idx;
    pend_t p;
    cmd_valid = v; cmd_write = w; cmd_addr = a; cmd_data = dd;
    cmd_mask = m; cmd_id = id; io_stall = st;
    #1;
    er = io_resetn && !st && (q.size() < MAX_INFLIGHT);
    check("cmd_ready", cmd_ready, er);
    rv = rsp_valid; rd = rsp_data; rid = rsp_id;
    if (q.size() > 0 && q[0].due == t) begin
      check("rsp_valid", rv, 1);
      check("rsp_data", rd & q[0].k, q[0].d & q[0].k);
      check("rsp_id", rid, q[0].id);
      void'(q.pop_front());
    end else begin
      check("rsp_valid_idle", rv, 0);
      check("rsp_data_idle", rd, 0);
      check("rsp_id_idle", rid, 0);
    end
    acc = v && cmd_ready;
    if (v && er) begin
      idx = int'((a >> 3) % DEPTH);
      if (w) begin
        for (int b = 0; b < 8; b++) begin
          if (m[b]) begin
            m_data[idx][8*b +: 8]  = dd[8*b +: 8];
            m_known[idx][8*b +: 8] = 8'hFF;
          end
        end
      end else begin
        p.due = t + LATENCY; p.d = m_data[idx]; p.k = m_known[idx]; p.id = id;
        q.push_back(p);
      end
    end
    t++;
    @(negedge io_clk);
  endtask

  task automatic idle(output bit rv, output logic [63:0] rd, output logic [15:0] rid);
    bit acc;
    step(0, 0, 64'h0, 64'h0, 8'h0, 16'h0, 0, acc, rv, rd, rid);
  endtask

  // Assert reset at the current negedge; outputs must clear without a clock edge.
  task automatic pulse_reset();
    io_resetn = 1'b0;
    cmd_valid = 1'b0;
    #1;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_id", rsp_id, 0);
    q.delete();
    @(posedge io_clk);
    @(negedge io_clk);
    io_resetn = 1'b1;
  endtask

  typedef struct {
    bit          w;
    logic [63:0] a;
    logic [63:0] d;
    logic [7:0]  m;
    logic [15:0] id;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    bit          acc, rv;
    logic [63:0] rd;
    logic [15:0] rid;
    int          n;

    for (int i = 0; i < DEPTH; i++) begin
      m_data[i] = '0; m_known[i] = '0;
    end
    io_resetn = 1'b0; io_stall = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_data = '0; cmd_mask = '0; cmd_id = '0;
    #1;
    check("init_cmd_ready", cmd_ready, 0);
    check("init_rsp_valid", rsp_valid, 0);
    check("init_rsp_data", rsp_data, 0);
    check("init_rsp_id", rsp_id, 0);
    repeat (2) @(posedge io_clk);
    @(negedge io_clk);
    io_resetn = 1'b1;

    vecs[0] = '{1, 64'h10,  64'h1122334455667788, 8'hFF, 16'h0000, 64'h0};
    vecs[1] = '{0, 64'h10,  64'h0,                8'h00, 16'h00A5, 64'h1122334455667788};
    vecs[2] = '{1, 64'h0,   64'hFFFFFFFFFFFFFFFF, 8'hFF, 16'h0000, 64'h0};
    vecs[3] = '{1, 64'h0,   64'h0,                8'h0F, 16'h0000, 64'h0};
    vecs[4] = '{0, 64'h0,   64'h0,                8'h00, 16'h0001, 64'hFFFFFFFF00000000};
    vecs[5] = '{1, 64'h800, 64'hDEADBEEFCAFEF00D, 8'hFF, 16'h0000, 64'h0};
    vecs[6] = '{0, 64'h0,   64'h0,                8'h00, 16'h0002, 64'hDEADBEEFCAFEF00D};
    vecs[7] = '{1, 64'h10,  64'h0,                8'h00, 16'h0000, 64'h0};
    vecs[8] = '{0, 64'h17,  64'h0,                8'h00, 16'h0003, 64'h1122334455667788};

    for (int i = 0; i < 9; i++) begin
      step(1, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].m, vecs[i].id, 0, acc, rv, rd, rid);
      check($sformatf("vec%0d_accept", i), acc, 1);
      if (!vecs[i].w) begin
        n = 0;
        rv = 0;
        while (!rv && n < 8) begin
          idle(rv, rd, rid);
          n++;
        end
        check($sformatf("vec%0d_latency", i), n, LATENCY);
        check($sformatf("vec%0d_data", i), rd, vecs[i].exp);
        check($sformatf("vec%0d_id", i), rid, vecs[i].id);
      end
    end

    // Store in the cycle after a load must not leak into that load's data.
    step(1, 0, 64'h10, 64'h0, 8'h00, 16'h0007, 0, acc, rv, rd, rid);
    step(1, 1, 64'h10, 64'h5555AAAA5555AAAA, 8'hFF, 16'h0, 0, acc, rv, rd, rid);
    idle(rv, rd, rid);
    check("ld_then_st_valid", rv, 1);
    check("ld_then_st_data", rd, 64'h1122334455667788);

    // Back-to-back loads with cmd_valid held high.
    step(1, 0, 64'h0, 64'h0, 8'h00, 16'h0010, 0, acc, rv, rd, rid);
    check("b2b_acc0", acc, 1);
    step(1, 0, 64'h8, 64'h0, 8'h00, 16'h0011, 0, acc, rv, rd, rid);
    check("b2b_acc1", acc, 1);
    step(1, 0, 64'h10, 64'h0, 8'h00, 16'h0012, 0, acc, rv, rd, rid);
    check("b2b_blocked", acc, 0);
    check("b2b_rsp0_id", rid, 16'h0010);
    step(1, 0, 64'h10, 64'h0, 8'h00, 16'h0012, 0, acc, rv, rd, rid);
    check("b2b_resume", acc, 1);
    check("b2b_rsp1_id", rid, 16'h0011);
    idle(rv, rd, rid);
    idle(rv, rd, rid);
    check("b2b_rsp2_id", rid, 16'h0012);
    check("b2b_rsp2_data", rd, 64'h5555AAAA5555AAAA);

    // Stall holds off acceptance regardless of cmd_valid.
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 64'h10, 64'h0, 8'h00, 16'h0020, 1, acc, rv, rd, rid);
      check("stall_no_accept", acc, 0);
      check("stall_no_rsp", rv, 0);
    end
    step(1, 0, 64'h10, 64'h0, 8'h00, 16'h0021, 0, acc, rv, rd, rid);
    check("stall_release_accept", acc, 1);
    idle(rv, rd, rid);
    idle(rv, rd, rid);
    check("stall_release_rsp", rid, 16'h0021);

    // Reset landing exactly when a response would be visible.
    step(1, 0, 64'h10, 64'h0, 8'h00, 16'h0030, 0, acc, rv, rd, rid);
    idle(rv, rd, rid);
    pulse_reset();

    // Reset one cycle after a load accept: no response, memory retained.
    step(1, 0, 64'h10, 64'h0, 8'h00, 16'h0077, 0, acc, rv, rd, rid);
    check("rst_mid_first_accept", acc, 1);
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      idle(rv, rd, rid);
      check("rst_mid_no_rsp", rv, 0);
    end
    step(1, 0, 64'h10, 64'h0, 8'h00, 16'h0078, 0, acc, rv, rd, rid);
    check("rst_mid_reload_accept", acc, 1);
    idle(rv, rd, rid);
    idle(rv, rd, rid);
    check("rst_mid_reload_data", rd, 64'h5555AAAA5555AAAA);

    // Randomized traffic over a small word pool with random upper address bits.
    for (int i = 0; i < 800; i++) begin
      logic [63:0] a, d;
      logic [7:0]  m;
      a = {$urandom, $urandom};
      a[10:3] = 8'($urandom_range(0, 11));
      d = {$urandom, $urandom};
      m = ($urandom_range(0, 9) < 3) ? 8'hFF : 8'($urandom);
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, a, d, m,
           16'($urandom), $urandom_range(0, 9) < 2, acc, rv, rd, rid);
    end
    for (int i = 0; i < LATENCY + 1; i++) idle(rv, rd, rid);
    check("drain_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
